// File: rtl/strobe_period_meter.sv
// strobe_period_meter: measures the CLK-cycle spacing between single-cycle
// enable strobes. It reports each period, checks it against an expected
// divide factor, and keeps lock and sticky-error status.
module strobe_period_meter #(
  parameter int WIDTH      = 16,
  parameter int EXPECTED   = 15,
  parameter int TOLERANCE  = 0,
  parameter int LOCK_COUNT = 4
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             CE,
  input  logic             STB,
  output logic [WIDTH-1:0] PERIOD,
  output logic             VALID,
  output logic             MATCH,
  output logic             LOCK,
  output logic             ERR,
  output logic             OVF
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  // Counter ceiling; reaching it without a strobe is an overflow.
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  // Expected period and tolerance carried one bit wider so that the
  // absolute difference never wraps.
  localparam logic [WIDTH:0]   EXP_W   = (WIDTH+1)'(EXPECTED);
  localparam logic [WIDTH:0]   TOL_W   = (WIDTH+1)'(TOLERANCE);
  localparam logic [7:0]       LOCK_W  = 8'(LOCK_COUNT);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] period_nxt;
  logic [7:0]       mcnt;
  logic [7:0]       mcnt_nxt;
  logic             valid_nxt;
  logic             match_nxt;
  logic             lock_nxt;
  logic             err_nxt;
  logic             ovf_nxt;

  // |p - EXPECTED| <= TOLERANCE, evaluated unsigned in WIDTH+1 bits.
  function automatic logic in_tol(input logic [WIDTH-1:0] p);
    logic [WIDTH:0] pe;
    logic [WIDTH:0] diff;
    pe = {1'b0, p};
    if (pe >= EXP_W) begin
      diff = pe - EXP_W;
    end else begin
      diff = EXP_W - pe;
    end
    return (diff <= TOL_W);
  endfunction

  // Match counter increment, saturating at the lock threshold.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c >= LOCK_W) ? LOCK_W : (c + 8'd1);
  endfunction

  // State register.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, counter and status decode; CE low overrides everything.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    period_nxt = PERIOD;
    valid_nxt  = 1'b0;
    match_nxt  = MATCH;
    mcnt_nxt   = mcnt;
    lock_nxt   = LOCK;
    err_nxt    = ERR;
    ovf_nxt    = 1'b0;

    if (!CE) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      mcnt_nxt  = 8'd0;
      lock_nxt  = 1'b0;
      err_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A strobe coinciding with CE rising is not taken here.
          state_nxt = ARMED;
          cnt_nxt   = '0;
        end
        ARMED: begin
          if (STB) begin
            state_nxt = MEASURE;
            cnt_nxt   = CNT_ONE;
          end
        end
        MEASURE: begin
          if (STB) begin
            // Closing strobe wins over saturation in the same cycle.
            period_nxt = cnt;
            valid_nxt  = 1'b1;
            cnt_nxt    = CNT_ONE;
            match_nxt  = in_tol(cnt);
            if (match_nxt) begin
              mcnt_nxt = sat_inc(mcnt);
              lock_nxt = (mcnt_nxt == LOCK_W);
            end else begin
              mcnt_nxt = 8'd0;
              lock_nxt = 1'b0;
              err_nxt  = ERR | LOCK;
            end
          end else if (cnt == CNT_MAX) begin
            // No strobe before saturation: count as a mismatch and re-arm.
            ovf_nxt   = 1'b1;
            state_nxt = ARMED;
            cnt_nxt   = '0;
            mcnt_nxt  = 8'd0;
            lock_nxt  = 1'b0;
            err_nxt   = ERR | LOCK;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Counter, match counter and registered outputs.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      cnt    <= '0;
      mcnt   <= 8'd0;
      PERIOD <= '0;
      VALID  <= 1'b0;
      MATCH  <= 1'b0;
      LOCK   <= 1'b0;
      ERR    <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      mcnt   <= mcnt_nxt;
      PERIOD <= period_nxt;
      VALID  <= valid_nxt;
      MATCH  <= match_nxt;
      LOCK   <= lock_nxt;
      ERR    <= err_nxt;
      OVF    <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_strobe_period_meter.sv
// Directed testbench for strobe_period_meter: three instances cover the
// nominal configuration, a nonzero tolerance and a narrow counter.
module tb_strobe_period_meter;

  logic        clk;
  logic        clr_n;
  logic [2:0]  ce;
  logic [2:0]  stb;

  logic [15:0] per0;
  logic        vld0, mat0, lck0, err0, ovf0;
  logic [15:0] per1;
  logic        vld1, mat1, lck1, err1, ovf1;
  logic [3:0]  per2;
  logic        vld2, mat2, lck2, err2, ovf2;

  int n_chk;
  int n_fail;

  strobe_period_meter #(.WIDTH(16), .EXPECTED(15), .TOLERANCE(0), .LOCK_COUNT(4)) u0 (
    .CLK(clk), .CLR_N(clr_n), .CE(ce[0]), .STB(stb[0]),
    .PERIOD(per0), .VALID(vld0), .MATCH(mat0), .LOCK(lck0), .ERR(err0), .OVF(ovf0)
  );

  strobe_period_meter #(.WIDTH(16), .EXPECTED(15), .TOLERANCE(1), .LOCK_COUNT(4)) u1 (
    .CLK(clk), .CLR_N(clr_n), .CE(ce[1]), .STB(stb[1]),
    .PERIOD(per1), .VALID(vld1), .MATCH(mat1), .LOCK(lck1), .ERR(err1), .OVF(ovf1)
  );

  strobe_period_meter #(.WIDTH(4), .EXPECTED(5), .TOLERANCE(0), .LOCK_COUNT(4)) u2 (
    .CLK(clk), .CLR_N(clr_n), .CE(ce[2]), .STB(stb[2]),
    .PERIOD(per2), .VALID(vld2), .MATCH(mat2), .LOCK(lck2), .ERR(err2), .OVF(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe on instance k exactly n cycles after its previous strobe.
  task automatic gap(input int k, input int n);
    repeat (n - 1) tick();
    stb[k] = 1'b1;
    tick();
    stb[k] = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clr_n  = 1'b0;
    ce     = 3'b000;
    stb    = 3'b000;

    #2;
    chk("rst_period", 32'(per0), 0);
    chk("rst_valid",  32'(vld0), 0);
    chk("rst_match",  32'(mat0), 0);
    chk("rst_lock",   32'(lck0), 0);
    chk("rst_err",    32'(err0), 0);
    chk("rst_ovf",    32'(ovf0), 0);

    tick();
    tick();
    clr_n = 1'b1;
    tick();

    // ---------------- instance 0: nominal lock ----------------
    ce[0] = 1'b1;
    tick();
    stb[0] = 1'b1;
    tick();
    stb[0] = 1'b0;
    chk("first_stb_novalid", 32'(vld0), 0);

    for (int i = 1; i <= 4; i++) begin
      gap(0, 15);
      chk("p15_valid",  32'(vld0), 1);
      chk("p15_period", 32'(per0), 15);
      chk("p15_match",  32'(mat0), 1);
      chk("p15_lock",   32'(lck0), (i == 4) ? 1 : 0);
      chk("p15_err",    32'(err0), 0);
    end

    // valid is a single-cycle pulse
    tick();
    chk("valid_pulse", 32'(vld0), 0);
    chk("lock_hold",   32'(lck0), 1);
    // short gap of 14 while locked
    repeat (12) tick();
    stb[0] = 1'b1;
    tick();
    stb[0] = 1'b0;
    chk("p14_valid",  32'(vld0), 1);
    chk("p14_period", 32'(per0), 14);
    chk("p14_match",  32'(mat0), 0);
    chk("p14_lock",   32'(lck0), 0);
    chk("p14_err",    32'(err0), 1);

    for (int i = 1; i <= 4; i++) begin
      gap(0, 15);
      chk("relock_period", 32'(per0), 15);
      chk("relock_lock",   32'(lck0), (i == 4) ? 1 : 0);
      chk("relock_err",    32'(err0), 1);
    end

    // CE falls together with a strobe while locked
    repeat (14) tick();
    stb[0] = 1'b1;
    ce[0]  = 1'b0;
    tick();
    stb[0] = 1'b0;
    chk("cedrop_valid",  32'(vld0), 0);
    chk("cedrop_lock",   32'(lck0), 0);
    chk("cedrop_err",    32'(err0), 0);
    chk("cedrop_period", 32'(per0), 15);

    // asynchronous clear mid-count
    ce[0] = 1'b1;
    tick();
    stb[0] = 1'b1;
    tick();
    stb[0] = 1'b0;
    repeat (3) tick();
    #2;
    clr_n = 1'b0;
    #1;
    chk("aclr_period", 32'(per0), 0);
    chk("aclr_match",  32'(mat0), 0);
    chk("aclr_valid",  32'(vld0), 0);
    chk("aclr_lock",   32'(lck0), 0);
    chk("aclr_err",    32'(err0), 0);
    chk("aclr_ovf",    32'(ovf0), 0);
    tick();
    clr_n = 1'b1;
    tick();
    stb[0] = 1'b1;
    tick();
    stb[0] = 1'b0;
    chk("resume_first_novalid", 32'(vld0), 0);
    gap(0, 15);
    chk("resume_valid",  32'(vld0), 1);
    chk("resume_period", 32'(per0), 15);

    // STB held high for three cycles after arming
    ce[0] = 1'b0;
    tick();
    ce[0] = 1'b1;
    tick();
    stb[0] = 1'b1;
    tick();
    chk("cont_c1_valid", 32'(vld0), 0);
    tick();
    chk("cont_c2_valid",  32'(vld0), 1);
    chk("cont_c2_period", 32'(per0), 1);
    tick();
    chk("cont_c3_valid",  32'(vld0), 1);
    chk("cont_c3_period", 32'(per0), 1);
    stb[0] = 1'b0;

    // strobe coincident with CE rising is ignored
    ce[0] = 1'b0;
    tick();
    ce[0]  = 1'b1;
    stb[0] = 1'b1;
    tick();
    stb[0] = 1'b0;
    repeat (3) tick();
    stb[0] = 1'b1;
    tick();
    stb[0] = 1'b0;
    chk("cerise_first_novalid", 32'(vld0), 0);
    gap(0, 2);
    chk("cerise_valid",  32'(vld0), 1);
    chk("cerise_period", 32'(per0), 2);

    // ---------------- instance 1: tolerance 1 ----------------
    ce[1] = 1'b1;
    tick();
    stb[1] = 1'b1;
    tick();
    stb[1] = 1'b0;
    gap(1, 14);
    chk("tol_p14_period", 32'(per1), 14);
    chk("tol_p14_match",  32'(mat1), 1);
    chk("tol_p14_lock",   32'(lck1), 0);
    gap(1, 16);
    chk("tol_p16_period", 32'(per1), 16);
    chk("tol_p16_match",  32'(mat1), 1);
    chk("tol_p16_lock",   32'(lck1), 0);
    gap(1, 15);
    chk("tol_p15_match",  32'(mat1), 1);
    chk("tol_p15_lock",   32'(lck1), 0);
    gap(1, 17);
    chk("tol_p17_period", 32'(per1), 17);
    chk("tol_p17_match",  32'(mat1), 0);
    chk("tol_p17_lock",   32'(lck1), 0);
    chk("tol_err",        32'(err1), 0);

    // ---------------- instance 2: WIDTH=4 overflow ----------------
    ce[2] = 1'b1;
    tick();
    stb[2] = 1'b1;
    tick();
    stb[2] = 1'b0;
    repeat (14) tick();
    chk("ovf_not_yet", 32'(ovf2), 0);
    tick();
    chk("ovf_pulse",    32'(ovf2), 1);
    chk("ovf_novalid",  32'(vld2), 0);
    chk("ovf_noperiod", 32'(per2), 0);
    tick();
    chk("ovf_one_cycle", 32'(ovf2), 0);
    stb[2] = 1'b1;
    tick();
    stb[2] = 1'b0;
    chk("rearm_first_novalid", 32'(vld2), 0);
    gap(2, 5);
    chk("rearm_valid",  32'(vld2), 1);
    chk("rearm_period", 32'(per2), 5);
    chk("rearm_match",  32'(mat2), 1);
    // strobe lands exactly on saturation
    gap(2, 15);
    chk("sat_stb_valid",  32'(vld2), 1);
    chk("sat_stb_period", 32'(per2), 15);
    chk("sat_stb_noovf",  32'(ovf2), 0);
    chk("sat_stb_match",  32'(mat2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
